fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the 16-bit instruction ROM. It owns the program counter and drives the ROM byte address. It captures the returned instruction into an IF/ID pipeline register for the decoder. It also handles stall, branch/jump redirect with flush, and a halt when the PC leaves the populated ROM range.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
IMEM_BYTES, 32, populated ROM size in bytes (16 words x 2); PC >= IMEM_BYTES halts fetch.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
stall  input  1  hazard stall from decode; holds PC and IF/ID.
redirect_valid  input  1  taken branch/jump resolved downstream.
redirect_target  input  16  byte address of the next instruction on redirect.
imem_pc  output  16  byte address to the instruction ROM; equals pc_q, combinational.
imem_instr  input  16  ROM data for imem_pc, combinational, same cycle.
if_id_valid  output  1  IF/ID register holds a real instruction.
if_id_instr  output  16  captured instruction.
if_id_pc  output  16  byte address of if_id_instr.
if_id_pc_plus2  output  16  if_id_pc + 2, modulo 2^16.
halted  output  1  fetch stopped, PC out of range.
misaligned  output  1  sticky; set when a redirect target has bit 0 = 1.
fetch_count  output  16  number of instructions captured into IF/ID; saturates at 16'hFFFF.

Behaviour:
- State is held in one register: RUN or HALT.
- Reset, which takes effect at the clock edge while rst=1:
  - pc_q=RESET_PC, state=RUN.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus2=0.
  - halted=0, misaligned=0, fetch_count=0.
  - Reset applied mid-stream discards the in-flight IF/ID contents. The first valid capture occurs on the first edge with rst=0.
- Per-edge priority is rst > redirect > stall > state action.
- Redirect (redirect_valid=1), in either state and regardless of stall:
  - pc_q <= {redirect_target[15:1],1'b0}.
  - if_id_valid <= 0 (flush of the wrong-path instruction).
  - state <= RUN, halted <= 0.
  - If redirect_target[0]=1, misaligned <= 1. The flag stays set until reset.
  - IF/ID data fields hold their values; only valid clears.
- Stall (stall=1, no redirect): pc_q, all IF/ID fields, state and fetch_count hold.
- RUN, no stall/redirect, pc_q < IMEM_BYTES:
  - IF/ID <= {1, imem_instr, pc_q, pc_q+2}.
  - pc_q <= pc_q+2, wrapping 16'hFFFE -> 16'h0000.
  - fetch_count increments, saturating.
- RUN, no stall/redirect, pc_q >= IMEM_BYTES:
  - state <= HALT, halted <= 1, if_id_valid <= 0.
  - pc_q holds; no capture.
- HALT, no redirect: pc_q holds, if_id_valid=0, halted=1. Stall is irrelevant in this state.
- Latency: an instruction at address A appears in IF/ID one edge after pc_q=A. There is one bubble after a redirect (the flushed cycle), and the target instruction is valid on the following edge.
- An all-zero instruction is an ordinary NOP: it is captured with valid=1 and is not treated as a halt.
- The block never reads the ROM beyond presenting imem_pc; ROM out-of-range data is don't-care because capture is suppressed.

Test Plan:
- Reset then 4 free-running cycles: imem_pc sequence 0,2,4,6. The IF/ID pc sequence lags by one cycle with valid=1, and fetch_count=4 after the 4th edge.
- Stall held high at pc_q=6 for 3 cycles: imem_pc stays 6, IF/ID stays {pc=4}, and fetch_count is unchanged. After release, pc_q goes 6->8 with IF/ID pc=6.
- redirect_valid=1, target=16'h0004, while pc_q=16'h0010: next edge pc_q=4 and if_id_valid=0. The following edge captures pc=4, valid=1.
- Redirect and stall in the same cycle, target=2: the redirect wins, so pc_q=2 and valid=0.
- Run sequentially from 0: after capturing pc=30, pc_q=32. The next edge sets halted=1 and valid=0, and pc_q stays 32 for 5 more cycles. Then redirect to 0: halted=0, and fetch resumes at 0.
- Redirect target=16'h0007: pc_q=6 and misaligned=1. The flag persists through further redirects and clears only on rst. Assert rst mid-run at pc=10: next edge pc=0, if_id_valid=0, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Handles stall, redirect with one-cycle flush, and halts when the PC leaves the ROM.
module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int unsigned IMEM_BYTES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_target,
   output logic [15:0] imem_pc,
   input  logic [15:0] imem_instr,
   output logic        if_id_valid,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc,
   output logic [15:0] if_id_pc_plus2,
   output logic        halted,
   output logic        misaligned,
   output logic [15:0] fetch_count
);

   localparam int unsigned PC_W    = 16;
   localparam logic [PC_W:0] PC_LIM = (PC_W+1)'(IMEM_BYTES);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [PC_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0] ifpc_q, ifpc_d;
   logic [PC_W-1:0] ifpc2_q, ifpc2_d;
   logic            halted_q, halted_d;
   logic            mis_q, mis_d;
   logic [PC_W-1:0] cnt_q, cnt_d;
   logic            in_range;

   assign in_range = ({1'b0, pc_q} < PC_LIM);

   // Next-state: redirect beats stall, stall beats the normal state action
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ifpc_d   = ifpc_q;
      ifpc2_d  = ifpc2_q;
      halted_d = halted_q;
      mis_d    = mis_q;
      cnt_d    = cnt_q;

      if (redirect_valid) begin
         pc_d     = {redirect_target[PC_W-1:1], 1'b0};
         valid_d  = 1'b0;
         state_d  = ST_RUN;
         halted_d = 1'b0;
         if (redirect_target[0]) begin
            mis_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (!stall) begin
                  if (in_range) begin
                     valid_d = 1'b1;
                     instr_d = imem_instr;
                     ifpc_d  = pc_q;
                     ifpc2_d = pc_q + PC_W'(2);
                     pc_d    = pc_q + PC_W'(2);
                     if (cnt_q != {PC_W{1'b1}}) begin
                        cnt_d = cnt_q + PC_W'(1);
                     end
                  end else begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                     valid_d  = 1'b0;
                  end
               end
            end
            ST_HALT: begin
               valid_d  = 1'b0;
               halted_d = 1'b1;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         ifpc_q   <= '0;
         ifpc2_q  <= '0;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ifpc_q   <= ifpc_d;
         ifpc2_q  <= ifpc2_d;
         halted_q <= halted_d;
         mis_q    <= mis_d;
         cnt_q    <= cnt_d;
      end
   end

   assign imem_pc        = pc_q;
   assign if_id_valid    = valid_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc       = ifpc_q;
   assign if_id_pc_plus2 = ifpc2_q;
   assign halted         = halted_q;
   assign misaligned     = mis_q;
   assign fetch_count    = cnt_q;

endmodule
